// File: rtl/instr_encoder.sv
// Instruction encoder: packs a decoded request (data-processing, memory or
// branch) into a 32-bit instruction word and queues it in a 4-entry FIFO.
//
// Ports:
//   clk, reset          - single clock, synchronous active-high reset
//   in_valid/in_ready   - request handshake; in_ready high while count < 4
//   in_kind             - 00 DP, 01 MEM, 10 branch, 11 reserved (dropped, err pulse)
//   in_cond             - condition field, copied to instr[31:28]
//   in_cmd              - DP opcode select, or MEM load/store in bit 0
//   in_imm_en, in_s     - DP immediate-operand and set-flags bits
//   in_rd, in_rn, in_rm - register fields
//   in_imm              - immediate; DP [7:0], MEM [11:0], branch [23:0]
//   out_valid/out_ready - head-of-FIFO handshake
//   out_instr           - head word, forced to 0 while the FIFO is empty
//   err                 - one-cycle pulse after a reserved request is accepted
//   count               - FIFO occupancy, 0..4
module instr_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_kind,
  input  logic [3:0]  in_cond,
  input  logic [1:0]  in_cmd,
  input  logic        in_imm_en,
  input  logic        in_s,
  input  logic [3:0]  in_rd,
  input  logic [3:0]  in_rn,
  input  logic [3:0]  in_rm,
  input  logic [23:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        err,
  output logic [2:0]  count
);

  localparam logic [1:0] KindDp   = 2'b00;
  localparam logic [1:0] KindMem  = 2'b01;
  localparam logic [1:0] KindBr   = 2'b10;
  localparam logic [2:0] CountMax = 3'd4;

  logic [31:0] mem_q [4];
  logic [1:0]  wptr_q, rptr_q;
  logic [2:0]  count_q;
  logic        err_q;

  logic        accept, push, pop, reserved;
  logic [31:0] enc;
  logic [3:0]  cmd4;
  logic [11:0] src2;

  // Word packing
  always_comb begin
    cmd4 = 4'b0000;
    src2 = 12'h000;
    enc  = 32'h0000_0000;
    unique case (in_cmd)
      2'b00:   cmd4 = 4'b0100;  // ADD
      2'b01:   cmd4 = 4'b0010;  // SUB
      2'b10:   cmd4 = 4'b0000;  // AND
      default: cmd4 = 4'b1100;  // ORR
    endcase
    src2 = in_imm_en ? {4'b0000, in_imm[7:0]} : {8'h00, in_rm};
    case (in_kind)
      KindDp:  enc = {in_cond, 2'b00, in_imm_en, cmd4, in_s, in_rn, in_rd, src2};
      // Immediate offset, pre-index, add, word access, no writeback.
      KindMem: enc = {in_cond, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, in_cmd[0],
                      in_rn, in_rd, in_imm[11:0]};
      KindBr:  enc = {in_cond, 4'b1010, in_imm};
      default: enc = 32'h0000_0000;
    endcase
  end

  // Handshakes; in_ready depends only on the registered count, so a pop on
  // a full edge cannot open the door for a same-edge push.
  always_comb begin
    in_ready  = (count_q < CountMax);
    out_valid = (count_q != 3'd0);
    accept    = in_valid & in_ready;
    reserved  = (in_kind == 2'b11);
    push      = accept & ~reserved;
    pop       = out_valid & out_ready;
    out_instr = out_valid ? mem_q[rptr_q] : 32'h0000_0000;
    err       = err_q;
    count     = count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= 2'd0;
      rptr_q  <= 2'd0;
      count_q <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      err_q <= accept & reserved;
      if (push) wptr_q <= wptr_q + 2'd1;
      if (pop)  rptr_q <= rptr_q + 2'd1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: out_instr is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wptr_q] <= enc;
  end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_kind;
  logic [3:0]  in_cond;
  logic [1:0]  in_cmd;
  logic        in_imm_en;
  logic        in_s;
  logic [3:0]  in_rd, in_rn, in_rm;
  logic [23:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        err;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  instr_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_kind   (in_kind),
    .in_cond   (in_cond),
    .in_cmd    (in_cmd),
    .in_imm_en (in_imm_en),
    .in_s      (in_s),
    .in_rd     (in_rd),
    .in_rn     (in_rn),
    .in_rm     (in_rm),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .err       (err),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] kind, input logic [3:0] cond, input logic [1:0] cmd,
                         input logic ie, input logic s, input logic [3:0] rd,
                         input logic [3:0] rn, input logic [3:0] rm, input logic [23:0] imm);
    in_valid  = 1'b1;
    in_kind   = kind;
    in_cond   = cond;
    in_cmd    = cmd;
    in_imm_en = ie;
    in_s      = s;
    in_rd     = rd;
    in_rn     = rn;
    in_rm     = rm;
    in_imm    = imm;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_checks++;
    if (count !== 3'd0) begin
      n_fail++; $display("FAIL reset_count got %0d want 0", count);
    end
    n_checks++;
    if (out_valid !== 1'b0 || out_instr !== 32'h0) begin
      n_fail++; $display("FAIL reset_out got v=%b %h want v=0 0", out_valid, out_instr);
    end
    n_checks++;
    if (in_ready !== 1'b1 || err !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready_err got rdy=%b err=%b want 1 0", in_ready, err);
    end
  endtask

  task automatic test_dp();
    // ADD R1,R2,#5 with junk in unused upper immediate bits and Rm.
    set_req(2'b00, 4'hE, 2'b00, 1'b1, 1'b0, 4'd1, 4'd2, 4'hF, 24'hABCD05);
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'hE2821005 || count !== 3'd1) begin
      n_fail++;
      $display("FAIL dp_add_imm got v=%b %h cnt=%0d want v=1 e2821005 cnt=1",
               out_valid, out_instr, count);
    end
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL dp_trunc_err got %b want 0", err);
    end
    // Push ORR R7,R6,R9 (register operand) while popping the ADD.
    set_req(2'b00, 4'hE, 2'b11, 1'b0, 1'b0, 4'd7, 4'd6, 4'd9, 24'hFFFFFF);
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (count !== 3'd1 || out_instr !== 32'hE1867009) begin
      n_fail++;
      $display("FAIL dp_orr_pushpop got cnt=%0d %h want cnt=1 e1867009", count, out_instr);
    end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || out_instr !== 32'h0) begin
      n_fail++;
      $display("FAIL dp_drain got cnt=%0d v=%b %h want 0 0 0", count, out_valid, out_instr);
    end
    // Pop request on empty FIFO is ignored.
    tick();
    out_ready = 1'b0;
    n_checks++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL empty_pop got cnt=%0d v=%b want 0 0", count, out_valid);
    end
  endtask

  task automatic test_order();
    logic [31:0] exp [3];
    exp[0] = 32'hE0543005;
    exp[1] = 32'hE5910008;
    exp[2] = 32'hE5810008;
    set_req(2'b00, 4'hE, 2'b01, 1'b0, 1'b1, 4'd3, 4'd4, 4'd5, 24'h0);  // SUBS R3,R4,R5
    tick();
    set_req(2'b01, 4'hE, 2'b01, 1'b0, 1'b0, 4'd0, 4'd1, 4'd0, 24'h008);  // LDR
    tick();
    set_req(2'b01, 4'hE, 2'b00, 1'b0, 1'b0, 4'd0, 4'd1, 4'd0, 24'h008);  // STR
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (count !== 3'd3) begin
      n_fail++; $display("FAIL order_count got %0d want 3", count);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_instr !== exp[i]) begin
        n_fail++;
        $display("FAIL order_word%0d got v=%b %h want v=1 %h", i, out_valid, out_instr, exp[i]);
      end
      tick();
    end
    out_ready = 1'b0;
    n_checks++;
    if (count !== 3'd0) begin
      n_fail++; $display("FAIL order_empty got %0d want 0", count);
    end
  endtask

  task automatic test_branch();
    set_req(2'b10, 4'h0, 2'b11, 1'b1, 1'b1, 4'hF, 4'hF, 4'hF, 24'h000003);
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'h0A000003) begin
      n_fail++; $display("FAIL branch got v=%b %h want v=1 0a000003", out_valid, out_instr);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    // ADD R0,R0,#i -> E28000xx
    for (int i = 1; i <= 4; i++) begin
      set_req(2'b00, 4'hE, 2'b00, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 24'(i));
      tick();
    end
    set_req(2'b00, 4'hE, 2'b00, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 24'd5);
    n_checks++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_after4 got cnt=%0d rdy=%b want 4 0", count, in_ready);
    end
    tick();
    n_checks++;
    if (count !== 3'd4 || in_ready !== 1'b0 || out_instr !== 32'hE2800001) begin
      n_fail++;
      $display("FAIL fifth_held got cnt=%0d rdy=%b %h want 4 0 e2800001",
               count, in_ready, out_instr);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if (count !== 3'd3 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL full_pop_no_push got cnt=%0d rdy=%b want 3 1", count, in_ready);
    end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (count !== 3'd4) begin
      n_fail++; $display("FAIL fifth_accepted got cnt=%0d want 4", count);
    end
    out_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      n_checks++;
      if (out_instr !== (32'hE2800000 | 32'(i))) begin
        n_fail++;
        $display("FAIL wrap_drain%0d got %h want %h", i, out_instr, 32'hE2800000 | 32'(i));
      end
      tick();
    end
    out_ready = 1'b0;
    n_checks++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL wrap_empty got cnt=%0d v=%b want 0 0", count, out_valid);
    end
  endtask

  task automatic test_reserved();
    set_req(2'b00, 4'hE, 2'b00, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 24'd1);
    tick();
    set_req(2'b11, 4'hE, 2'b00, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 24'd9);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rsv_ready got %b want 1", in_ready);
    end
    tick();
    n_checks++;
    if (err !== 1'b1 || count !== 3'd1) begin
      n_fail++; $display("FAIL rsv_err got err=%b cnt=%0d want 1 1", err, count);
    end
    set_req(2'b00, 4'hE, 2'b00, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 24'd2);
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (err !== 1'b0 || count !== 3'd2) begin
      n_fail++; $display("FAIL rsv_pulse_end got err=%b cnt=%0d want 0 2", err, count);
    end
    out_ready = 1'b1;
    n_checks++;
    if (out_instr !== 32'hE2800001) begin
      n_fail++; $display("FAIL rsv_word0 got %h want e2800001", out_instr);
    end
    tick();
    n_checks++;
    if (out_instr !== 32'hE2800002) begin
      n_fail++; $display("FAIL rsv_word1 got %h want e2800002", out_instr);
    end
    tick();
    out_ready = 1'b0;
    n_checks++;
    if (count !== 3'd0) begin
      n_fail++; $display("FAIL rsv_empty got %0d want 0", count);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 1; i <= 3; i++) begin
      set_req(2'b00, 4'hE, 2'b00, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 24'(i));
      tick();
    end
    n_checks++;
    if (count !== 3'd3) begin
      n_fail++; $display("FAIL mid_prefill got %0d want 3", count);
    end
    out_ready = 1'b1;
    reset     = 1'b1;
    tick();
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || out_instr !== 32'h0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset got cnt=%0d v=%b %h rdy=%b want 0 0 0 1",
               count, out_valid, out_instr, in_ready);
    end
    tick();
    n_checks++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_hold got cnt=%0d v=%b want 0 0", count, out_valid);
    end
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_kind   = 2'b00;
    in_cond   = 4'h0;
    in_cmd    = 2'b00;
    in_imm_en = 1'b0;
    in_s      = 1'b0;
    in_rd     = 4'h0;
    in_rn     = 4'h0;
    in_rm     = 4'h0;
    in_imm    = 24'h0;
    #2;
    test_reset();
    test_dp();
    test_order();
    test_branch();
    test_back_to_back();
    test_reserved();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 in_valid  input  1  request present.
REQ-004 in_ready  output  1  encoder can accept; high iff FIFO count < 4.
REQ-005 in_kind  input  2  00 data-processing, 01 memory, 10 branch, 11 reserved.
REQ-006 in_cond  input  4  condition field copied to Instr[31:28].
REQ-007 in_cmd  input  2  DP: 00 ADD, 01 SUB, 10 AND, 11 ORR; MEM: bit0 = L (1 load, 0 store); ignored for branch.
REQ-008 in_imm_en  input  1  DP only: 1 immediate operand, 0 register operand.
REQ-009 in_s  input  1  DP only: set-flags bit.
REQ-010 in_rd, in_rn, in_rm  input  4 each  register fields.
REQ-011 in_imm  input  24  immediate; DP uses [7:0], MEM uses [11:0], branch uses [23:0].
REQ-012 out_valid  output  1  instruction word available at FIFO head.
REQ-013 out_ready  input  1  consumer takes the head word.
REQ-014 out_instr  output  32  head instruction word; 0 when out_valid low.
REQ-015 err  output  1  one-cycle pulse on a dropped reserved request.
REQ-016 count  output  3  FIFO occupancy, 0..4.

Function
REQ-017 Accept occurs on an edge where in_valid and in_ready are both high; push occurs on a pop-free or pop edge alike.
REQ-018 DP word: {cond, 00, I=in_imm_en, cmd4, S=in_s, Rn, Rd, src2}; cmd4 = ADD 0100, SUB 0010, AND 0000, ORR 1100; src2 = I ? {0000, imm[7:0]} : {00000000, Rm}.
REQ-019 MEM word: {cond, 01, 0, 1, 1, 0, 0, L, Rn, Rd, imm[11:0]} (immediate offset, pre-index, add, word, no writeback).
REQ-020 Branch word: {cond, 10, 10, imm[23:0]}; in_rd/in_rn/in_rm ignored.
REQ-021 Reserved kind: request accepted (handshake completes) but not enqueued; err high for exactly the following cycle; count unchanged.
REQ-022 Fields are truncated per REQ-011; unused upper bits never cause err.
REQ-023 Storage: 4-entry FIFO, 2-bit read/write pointers wrapping 3→0, separate occupancy counter.
REQ-024 Latency: word accepted at edge N is visible on out_instr with out_valid high in the cycle after edge N when the FIFO was empty.
REQ-025 Pop occurs on an edge where out_valid and out_ready are both high; next entry (if any) appears the following cycle.
REQ-026 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-027 Full (count 4): in_ready low; a pop on that edge does not enable a push on the same edge.
REQ-028 Empty: out_valid low; out_ready ignored, no pointer movement.
REQ-029 Order preserved: words leave in acceptance order; reserved requests leave no gap.

Reset
REQ-030 On an edge with reset high: pointers, count, err cleared; out_valid 0, out_instr 0, in_ready 1 in the next cycle.
REQ-031 Reset mid-operation discards all stored words and any request presented on the same edge.
REQ-032 Reset dominates simultaneous push/pop on the same edge.

Verification
REQ-033 ADD R1,R2,#5 cond 1110, S=0, empty FIFO -> next cycle out_valid=1, out_instr=0xE2821005, count=1.
REQ-034 SUBS R3,R4,R5 cond 1110 then LDR R0,[R1,#8] then STR R0,[R1,#8], out_ready=0 -> count=3; then out_ready=1 -> 0xE0543005, 0xE5910008, 0xE5810008 on successive cycles.
REQ-035 B cond 0000 imm 0x000003 -> out_instr=0x0A000003.
REQ-036 Five back-to-back requests, out_ready=0 -> in_ready low after fourth, fifth held; one pop -> fifth accepted next edge, count returns to 4; pointer wrap verified by draining in order.
REQ-037 in_kind=11 between two valid requests -> err pulse one cycle, count +0 for it, output sequence shows only the two valid words.
REQ-038 Reset asserted with count=3 while pushing and popping -> next cycle count=0, out_valid=0, out_instr=0, in_ready=1.
